// File: rtl/tau_pkg.sv
// Shared types and helpers for the tau core datapath: operand FSM states,
// the immediate select index and the one-hot decoder used by writeback.
package tau_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } route_state_e;

    // Widest register file the one-hot helper can address.
    localparam int unsigned MAX_REGS = 64;

    // Operand B index that selects the immediate: one past the last register.
    function automatic int unsigned imm_sel(input int unsigned num_regs);
        return num_regs;
    endfunction

    function automatic logic [MAX_REGS-1:0] onehot(input int unsigned idx);
        logic [MAX_REGS-1:0] v;
        v = '0;
        if (idx < MAX_REGS) begin
            v = {{(MAX_REGS-1){1'b0}}, 1'b1} << idx;
        end
        return v;
    endfunction

endpackage

// File: rtl/operand_router_skid.sv
// Generic two-entry valid/ready skid buffer with a registered in_ready.
// Handshake: a beat moves when valid && ready on a rising edge; out_valid and
// out_data hold steady until out_ready; in_ready never depends on out_ready
// combinationally.
module operand_skid_buf
    import tau_pkg::*;
#(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output route_state_e     state_o
);

    route_state_e     state_q, state_d;
    logic             in_ready_q;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             accept;

    assign accept = in_valid & in_ready_q;

    // State register; in_ready is the registered decode of the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != FULL);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (accept) state_d = ONE;
            end
            ONE: begin
                if (accept && !out_ready)      state_d = FULL;
                else if (!accept && out_ready) state_d = EMPTY;
                else                           state_d = ONE;
            end
            FULL: begin
                if (out_ready) state_d = ONE;
            end
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        data_d = data_q;
        skid_d = skid_q;
        case (state_q)
            EMPTY: begin
                if (accept) data_d = in_data;
            end
            ONE: begin
                if (accept && out_ready) data_d = in_data;
                else if (accept)         skid_d = in_data;
            end
            FULL: begin
                if (out_ready) data_d = skid_q;
            end
            default: begin
                data_d = '0;
                skid_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            skid_q <= '0;
        end else begin
            data_q <= data_d;
            skid_q <= skid_d;
        end
    end

    always_comb begin
        out_valid = 1'b0;
        in_ready  = in_ready_q;
        out_data  = data_q;
        state_o   = state_q;
        if (state_q != EMPTY) out_valid = 1'b1;
    end

endmodule

// File: rtl/operand_router.sv
// Operand select (A/B from the register file, B may take the immediate) in
// front of a skid buffer, plus a registered one-hot writeback steer.
module operand_router
    import tau_pkg::*;
#(
    parameter int WORD_SIZE = 8,
    parameter int NUM_REGS  = 8,
    parameter int SEL_W     = $clog2(NUM_REGS + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REGS*WORD_SIZE-1:0] regs_flat,
    input  logic [WORD_SIZE-1:0]          imm,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [SEL_W-1:0]              sel_a,
    input  logic [SEL_W-1:0]              sel_b,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WORD_SIZE-1:0]          op_a,
    output logic [WORD_SIZE-1:0]          op_b,
    output logic                          sel_err,
    input  logic                          wb_valid,
    input  logic [SEL_W-1:0]              wb_sel,
    input  logic [WORD_SIZE-1:0]          wb_data,
    output logic [NUM_REGS-1:0]           wr_en,
    output logic [WORD_SIZE-1:0]          wr_data,
    output logic                          wb_err,
    output route_state_e                  state_dbg
);

    localparam int unsigned IMM_IDX = imm_sel(NUM_REGS);
    localparam int          PAIR_W  = 2 * WORD_SIZE + 1;

    logic [WORD_SIZE-1:0] a_val, b_val;
    logic                 a_err, b_err;
    logic [PAIR_W-1:0]    pair_in, pair_out;

    // Unmatched selects fall through to zero, so a bad index never leaks data.
    always_comb begin
        a_val = '0;
        b_val = '0;
        a_err = (sel_a >= SEL_W'(NUM_REGS));
        b_err = (sel_b > SEL_W'(IMM_IDX));
        for (int k = 0; k < NUM_REGS; k++) begin
            if (sel_a == SEL_W'(k)) a_val = regs_flat[k*WORD_SIZE +: WORD_SIZE];
            if (sel_b == SEL_W'(k)) b_val = regs_flat[k*WORD_SIZE +: WORD_SIZE];
        end
        if (sel_b == SEL_W'(IMM_IDX)) b_val = imm;
    end

    assign pair_in = {a_err | b_err, a_val, b_val};

    operand_skid_buf #(
        .WIDTH (PAIR_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (pair_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (pair_out),
        .state_o   (state_dbg)
    );

    assign sel_err = pair_out[PAIR_W-1];
    assign op_a    = pair_out[2*WORD_SIZE-1:WORD_SIZE];
    assign op_b    = pair_out[WORD_SIZE-1:0];

    logic [NUM_REGS-1:0]  wr_en_q, wr_en_d;
    logic [WORD_SIZE-1:0] wr_data_q, wr_data_d;
    logic                 wb_err_q, wb_err_d;

    // Writeback runs beside the operand path; a bad index only raises wb_err.
    always_comb begin
        wr_en_d   = '0;
        wr_data_d = wr_data_q;
        wb_err_d  = 1'b0;
        if (wb_valid) begin
            if (wb_sel < SEL_W'(NUM_REGS)) begin
                wr_en_d   = NUM_REGS'(onehot(32'(wb_sel)));
                wr_data_d = wb_data;
            end else begin
                wb_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q   <= '0;
            wr_data_q <= '0;
            wb_err_q  <= 1'b0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            wb_err_q  <= wb_err_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_data = wr_data_q;
    assign wb_err  = wb_err_q;

endmodule

// File: tb/tb_operand_router.sv
// Directed bench for operand_router: reset, select, range, backpressure,
// throughput and writeback, with a pair scoreboard on the output handshake.
module tb_operand_router;
    import tau_pkg::*;

    localparam int W = 8;
    localparam int N = 8;
    localparam int S = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [N*W-1:0]     regs_flat;
    logic [W-1:0]       imm;
    logic               in_valid;
    logic               in_ready;
    logic [S-1:0]       sel_a;
    logic [S-1:0]       sel_b;
    logic               out_valid;
    logic               out_ready;
    logic [W-1:0]       op_a;
    logic [W-1:0]       op_b;
    logic               sel_err;
    logic               wb_valid;
    logic [S-1:0]       wb_sel;
    logic [W-1:0]       wb_data;
    logic [N-1:0]       wr_en;
    logic [W-1:0]       wr_data;
    logic               wb_err;
    route_state_e       state_dbg;

    operand_router #(.WORD_SIZE(W), .NUM_REGS(N), .SEL_W(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .regs_flat (regs_flat),
        .imm       (imm),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel_a     (sel_a),
        .sel_b     (sel_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .sel_err   (sel_err),
        .wb_valid  (wb_valid),
        .wb_sel    (wb_sel),
        .wb_data   (wb_data),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .wb_err    (wb_err),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_deliv = 0;
    logic [W-1:0] rv [N];
    logic [2*W:0] exp_q [$];

    // Writeback table for the throughput window: drive, then expected result.
    logic         t_v   [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [S-1:0] t_s   [6] = '{4'd5, 4'd9, 4'd0, 4'd0, 4'd8, 4'd7};
    logic [W-1:0] t_d   [6] = '{8'hA7, 8'h12, 8'h00, 8'h3C, 8'h55, 8'hE1};
    logic [N-1:0] t_en  [6] = '{8'h20, 8'h00, 8'h00, 8'h01, 8'h00, 8'h80};
    logic [W-1:0] t_dat [6] = '{8'hA7, 8'hA7, 8'hA7, 8'h3C, 8'h3C, 8'hE1};
    logic         t_err [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_regs();
        for (int k = 0; k < N; k++) regs_flat[k*W +: W] = rv[k];
    endtask

    function automatic logic [2*W:0] model(input logic [S-1:0] sa, input logic [S-1:0] sb,
                                           input logic [W-1:0] im);
        logic [W-1:0] a, b;
        logic         e;
        a = '0;
        b = '0;
        e = 1'b0;
        if (sa < 4'd8) a = rv[sa[2:0]];
        else           e = 1'b1;
        if (sb < 4'd8)       b = rv[sb[2:0]];
        else if (sb == 4'd8) b = im;
        else                 e = 1'b1;
        return {e, a, b};
    endfunction

    // One clock: record the accept and delivery seen before the edge, then
    // score the delivered pair against the oldest expected one.
    task automatic cycle();
        logic         acc, dlv;
        logic [2*W:0] exp_in, got;
        acc    = in_valid && in_ready && rst_n;
        dlv    = out_valid && out_ready;
        exp_in = model(sel_a, sel_b, imm);
        got    = {sel_err, op_a, op_b};
        @(posedge clk);
        #1;
        if (dlv) begin
            n_deliv++;
            check("sb_has_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check("sb_pair", 32'(got), 32'(exp_q.pop_front()));
        end
        if (acc) exp_q.push_back(exp_in);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base, nvalid, stall;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sel_a = '0; sel_b = '0; imm = '0;
        wb_valid = 1'b0; wb_sel = '0; wb_data = '0;
        rv = '{8'h11, 8'h22, 8'h33, 8'h5A, 8'h44, 8'h55, 8'h66, 8'h77};
        set_regs();
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_op_a", 32'(op_a), 32'd0);
        check("rst_op_b", 32'(op_b), 32'd0);
        rst_n = 1'b1;

        // Register A, immediate B.
        in_valid = 1'b1; out_ready = 1'b1; sel_a = 4'd3; sel_b = 4'd8; imm = 8'hC3;
        cycle();
        check("sel_out_valid", 32'(out_valid), 32'd1);
        check("sel_op_a", 32'(op_a), 32'h5A);
        check("sel_op_b", 32'(op_b), 32'hC3);
        check("sel_err", 32'(sel_err), 32'd0);

        // Out-of-range selects and the last valid indices.
        sel_a = 4'd8; sel_b = 4'd2;
        cycle();
        check("range_a_op_a", 32'(op_a), 32'd0);
        check("range_a_op_b", 32'(op_b), 32'h33);
        check("range_a_err", 32'(sel_err), 32'd1);
        sel_a = 4'd1; sel_b = 4'd9;
        cycle();
        check("range_b_op_a", 32'(op_a), 32'h22);
        check("range_b_op_b", 32'(op_b), 32'd0);
        check("range_b_err", 32'(sel_err), 32'd1);
        sel_a = 4'd7; sel_b = 4'd0;
        cycle();
        check("edge_op_a", 32'(op_a), 32'h77);
        check("edge_op_b", 32'(op_b), 32'h11);
        check("edge_err", 32'(sel_err), 32'd0);
        in_valid = 1'b0;
        cycle();
        check("drain_out_valid", 32'(out_valid), 32'd0);
        check("drain_sb_empty", 32'(exp_q.size()), 32'd0);

        // Backpressure: two accepts fill the buffer, later reg writes must not leak in.
        base = n_deliv;
        out_ready = 1'b0; in_valid = 1'b1; sel_a = 4'd0; sel_b = 4'd1;
        cycle();
        check("bp_ready_after_1", 32'(in_ready), 32'd1);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        sel_a = 4'd2; sel_b = 4'd3;
        cycle();
        check("bp_ready_after_2", 32'(in_ready), 32'd0);
        for (int k = 0; k < N; k++) rv[k] = rv[k] ^ 8'hFF;
        set_regs();
        sel_a = 4'd4; sel_b = 4'd5;
        cycle();
        cycle();
        check("bp_hold_ready", 32'(in_ready), 32'd0);
        check("bp_hold_op_a", 32'(op_a), 32'h11);
        check("bp_hold_op_b", 32'(op_b), 32'h22);
        out_ready = 1'b1;
        cycle();
        check("bp_release_ready", 32'(in_ready), 32'd1);
        check("bp_skid_op_a", 32'(op_a), 32'h33);
        check("bp_skid_op_b", 32'(op_b), 32'h5A);
        cycle();
        check("bp_req2_op_a", 32'(op_a), 32'hBB);
        check("bp_req2_op_b", 32'(op_b), 32'hAA);
        sel_a = 4'd6; sel_b = 4'd8; imm = 8'h99;
        cycle();
        check("bp_req3_op_a", 32'(op_a), 32'h99);
        check("bp_req3_op_b", 32'(op_b), 32'h99);
        in_valid = 1'b0;
        cycle();
        check("bp_empty", 32'(out_valid), 32'd0);
        check("bp_delivered", 32'(n_deliv - base), 32'd4);
        check("bp_sb_empty", 32'(exp_q.size()), 32'd0);

        // Full throughput with writebacks running alongside.
        base = n_deliv; nvalid = 0; stall = 0;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; out_ready = 1'b1;
            sel_a = 4'(i % 8); sel_b = 4'((i * 5) % 9); imm = 8'(i * 17);
            if (i < 6) begin
                wb_valid = t_v[i]; wb_sel = t_s[i]; wb_data = t_d[i];
            end else begin
                wb_valid = 1'b0;
            end
            if (!in_ready) stall++;
            cycle();
            if (out_valid) nvalid++;
            if (i < 6) begin
                check("wb_wr_en", 32'(wr_en), 32'(t_en[i]));
                check("wb_wr_data", 32'(wr_data), 32'(t_dat[i]));
                check("wb_err", 32'(wb_err), 32'(t_err[i]));
            end
        end
        in_valid = 1'b0;
        cycle();
        check("tp_delivered", 32'(n_deliv - base), 32'd16);
        check("tp_valid_cycles", 32'(nvalid), 32'd16);
        check("tp_stalls", 32'(stall), 32'd0);
        check("tp_sb_empty", 32'(exp_q.size()), 32'd0);
        check("tp_idle", 32'(out_valid), 32'd0);

        // Reset while the buffer is full and a write strobe is live.
        out_ready = 1'b0; in_valid = 1'b1; sel_a = 4'd1; sel_b = 4'd2;
        wb_valid = 1'b1; wb_sel = 4'd3; wb_data = 8'h4D;
        cycle();
        cycle();
        check("pre_rst_out_valid", 32'(out_valid), 32'd1);
        check("pre_rst_in_ready", 32'(in_ready), 32'd0);
        check("pre_rst_wr_en", 32'(wr_en), 32'h08);
        #2;
        rst_n = 1'b0; in_valid = 1'b0; wb_valid = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_wr_en", 32'(wr_en), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_op_a", 32'(op_a), 32'd0);
        check("mid_rst_op_b", 32'(op_b), 32'd0);
        exp_q.delete();
        rst_n = 1'b1; out_ready = 1'b1;
        cycle();
        check("post_rst_no_pair", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
